// File: rtl/seg_pkg.sv
// Shared glyph constants and scan FSM state encoding for the timer's 7-segment displays.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   // BLANK is a lit slot showing nothing; OFF is the idle/gap drive. Same pattern, different intent.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_OFF   = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      GAP
   } state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder (active-low segments), zero latency.
// hex_en=0 renders 10..15 as blank; blank=1 forces blank regardless of nibble.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       hex_en,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = hex_en ? SEG_A : SEG_BLANK;
            4'hB:    seg = hex_en ? SEG_B : SEG_BLANK;
            4'hC:    seg = hex_en ? SEG_C : SEG_BLANK;
            4'hD:    seg = hex_en ? SEG_D : SEG_BLANK;
            4'hE:    seg = hex_en ? SEG_E : SEG_BLANK;
            default: seg = hex_en ? SEG_F : SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame input snapshot and anode-off gaps.
// All outputs registered: pins follow the FSM/index one cycle after each state change.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int CLK_DIV    = 50000,
   parameter int GAP_CYCLES = 2,
   parameter int HEX_EN     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  lz_blank,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t              state, state_nxt;
   logic [IW-1:0]       idx, idx_nxt;
   logic [DW-1:0]       dwell, dwell_nxt;
   logic [GW-1:0]       gap, gap_nxt;
   logic                snap_take, fd_nxt, adv;

   logic [4*DIGITS-1:0] snap_dig;
   logic [DIGITS-1:0]   snap_dp;
   logic                snap_lz;

   logic [3:0]          cur_nib;
   logic                cur_dp, cur_blank, run;
   logic [6:0]          glyph;
   logic [DIGITS-1:0]   an_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         dwell    <= '0;
         gap      <= '0;
         snap_dig <= '0;
         snap_dp  <= '0;
         snap_lz  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         dwell <= dwell_nxt;
         gap   <= gap_nxt;
         if (snap_take) begin
            snap_dig <= digits_in;
            snap_dp  <= dp_in;
            snap_lz  <= lz_blank;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      dwell_nxt = dwell;
      gap_nxt   = gap;
      snap_take = 1'b0;
      fd_nxt    = 1'b0;
      adv       = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         dwell_nxt = '0;
         gap_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = SHOW;
               idx_nxt   = '0;
               dwell_nxt = '0;
               gap_nxt   = '0;
               snap_take = 1'b1;
            end
            SHOW: begin
               if (dwell == DWELL_LAST) begin
                  dwell_nxt = '0;
                  if (GAP_CYCLES > 0) state_nxt = GAP;
                  else                adv       = 1'b1;
               end else begin
                  dwell_nxt = dwell + 1'b1;
               end
            end
            GAP: begin
               if (gap == GAP_LAST) begin
                  gap_nxt = '0;
                  adv     = 1'b1;
               end else begin
                  gap_nxt = gap + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
         // Wrapping past the last digit closes the frame and refreshes the snapshot.
         if (adv) begin
            state_nxt = SHOW;
            if (idx == IDX_LAST) begin
               idx_nxt   = '0;
               fd_nxt    = 1'b1;
               snap_take = 1'b1;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
      end
   end

   // Walk from the most significant digit down; run stays high while every nibble so far is zero.
   always_comb begin
      run       = snap_lz;
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         run = run & (snap_dig[4*k +: 4] == 4'h0);
         if (idx == IW'(k)) begin
            cur_nib   = snap_dig[4*k +: 4];
            cur_dp    = snap_dp[k];
            cur_blank = run && (k != 0);
         end
      end
   end

   always_comb begin
      an_nxt = '1;
      for (int k = 0; k < DIGITS; k++) begin
         an_nxt[k] = !((state == SHOW) && (idx == IW'(k)));
      end
   end

   seg_hex_decode u_dec (
      .nib    (cur_nib),
      .hex_en (HEX_EN != 0),
      .blank  (cur_blank),
      .seg    (glyph)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out    <= SEG_OFF;
         dp_out     <= 1'b1;
         an_out     <= '1;
         frame_done <= 1'b0;
      end else begin
         an_out     <= an_nxt;
         frame_done <= fd_nxt;
         if (state == SHOW) begin
            seg_out <= glyph;
            dp_out  <= ~cur_dp;
         end else begin
            seg_out <= SEG_OFF;
            dp_out  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with 4 digits, 4-cycle dwell, 1-cycle gap (20-cycle frame).
module tb_seg_scan_driver;

   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] GA = 7'b0001000;

   logic        clk = 1'b0;
   logic        rst_n, en, lz_blank;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [6:0]  seg_out, nh_seg;
   logic        dp_out, nh_dp, frame_done, nh_fd;
   logic [3:0]  an_out, nh_an;

   int tests = 0;
   int fails = 0;

   logic [3:0] cap_an  [0:39];
   logic [6:0] cap_seg [0:39];
   logic       cap_dp  [0:39];
   logic       cap_fd  [0:39];
   logic [6:0] cap_nh  [0:39];

   always #5 clk = ~clk;

   seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .GAP_CYCLES(1), .HEX_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in), .dp_in(dp_in),
      .lz_blank(lz_blank), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
      .frame_done(frame_done)
   );

   seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .GAP_CYCLES(1), .HEX_EN(0)) dut_nohex (
      .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in), .dp_in(dp_in),
      .lz_blank(lz_blank), .seg_out(nh_seg), .dp_out(nh_dp), .an_out(nh_an),
      .frame_done(nh_fd)
   );

   task automatic step_sample(input int c);
      @(negedge clk);
      cap_an[c]  = an_out;
      cap_seg[c] = seg_out;
      cap_dp[c]  = dp_out;
      cap_fd[c]  = frame_done;
      cap_nh[c]  = nh_seg;
   endtask

   // Leaves the bench one negedge after the IDLE->SHOW edge; the next sample is digit 0 lit.
   task automatic start_scan(input logic [15:0] d, input logic [3:0] p, input logic lz);
      en = 1'b0;
      repeat (2) @(negedge clk);
      digits_in = d;
      dp_in     = p;
      lz_blank  = lz;
      en        = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; digits_in = '0; dp_in = '0; lz_blank = 1'b0;
      #12;
      tests++; if (seg_out !== 7'b1111111) begin fails++; $display("FAIL reset_seg got %b want 1111111", seg_out); end
      tests++; if (dp_out !== 1'b1) begin fails++; $display("FAIL reset_dp got %b want 1", dp_out); end
      tests++; if (an_out !== 4'b1111) begin fails++; $display("FAIL reset_an got %b want 1111", an_out); end
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got %b want 0", frame_done); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (an_out !== 4'b1111) begin fails++; $display("FAIL idle_an got %b want 1111", an_out); end
   endtask

   task automatic test_basic();
      logic [6:0] exp_g [4];
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_fd;
      int         s;
      logic       lit;
      exp_g[0] = G4; exp_g[1] = G3; exp_g[2] = G2; exp_g[3] = G1;
      start_scan(16'h1234, 4'b0000, 1'b0);
      for (int c = 0; c < 40; c++) step_sample(c);
      for (int c = 0; c < 40; c++) begin
         s       = (c % 20) / 5;
         lit     = (c % 5) < 4;
         exp_an  = lit ? ~(4'b0001 << s) : 4'b1111;
         exp_seg = lit ? exp_g[s] : G_BLANK;
         exp_fd  = (c % 20) == 19;
         tests++; if (cap_an[c] !== exp_an) begin fails++; $display("FAIL basic_an c=%0d got %b want %b", c, cap_an[c], exp_an); end
         tests++; if (cap_seg[c] !== exp_seg) begin fails++; $display("FAIL basic_seg c=%0d got %b want %b", c, cap_seg[c], exp_seg); end
         tests++; if (cap_fd[c] !== exp_fd) begin fails++; $display("FAIL basic_fd c=%0d got %b want %b", c, cap_fd[c], exp_fd); end
         tests++; if (cap_dp[c] !== 1'b1) begin fails++; $display("FAIL basic_dp c=%0d got %b want 1", c, cap_dp[c]); end
      end
   endtask

   task automatic test_lz_hex();
      logic [6:0] exp_g [4];
      logic [3:0] exp_an;
      int         s;
      exp_g[0] = G0; exp_g[1] = GA; exp_g[2] = G_BLANK; exp_g[3] = G_BLANK;
      start_scan(16'h00A0, 4'b0000, 1'b1);
      for (int c = 0; c < 20; c++) step_sample(c);
      for (int c = 0; c < 20; c++) begin
         s = c / 5;
         if ((c % 5) < 4) begin
            exp_an = ~(4'b0001 << s);
            tests++; if (cap_an[c] !== exp_an) begin fails++; $display("FAIL lz_an c=%0d got %b want %b", c, cap_an[c], exp_an); end
            tests++; if (cap_seg[c] !== exp_g[s]) begin fails++; $display("FAIL lz_seg c=%0d got %b want %b", c, cap_seg[c], exp_g[s]); end
         end
      end
      tests++; if (cap_nh[5] !== G_BLANK) begin fails++; $display("FAIL nohex_digit1 got %b want %b", cap_nh[5], G_BLANK); end
      tests++; if (cap_nh[0] !== G0) begin fails++; $display("FAIL nohex_digit0 got %b want %b", cap_nh[0], G0); end
      tests++; if (cap_nh[10] !== G_BLANK) begin fails++; $display("FAIL nohex_digit2 got %b want %b", cap_nh[10], G_BLANK); end
   endtask

   task automatic test_zero_dp();
      logic [6:0] exp_seg;
      logic       exp_dp;
      int         s;
      start_scan(16'h0000, 4'b0100, 1'b1);
      for (int c = 0; c < 20; c++) step_sample(c);
      for (int c = 0; c < 20; c++) begin
         s = c / 5;
         if ((c % 5) < 4) begin
            exp_seg = (s == 0) ? G0 : G_BLANK;
            exp_dp  = (s == 2) ? 1'b0 : 1'b1;
            tests++; if (cap_seg[c] !== exp_seg) begin fails++; $display("FAIL zero_seg c=%0d got %b want %b", c, cap_seg[c], exp_seg); end
            tests++; if (cap_dp[c] !== exp_dp) begin fails++; $display("FAIL zero_dp c=%0d got %b want %b", c, cap_dp[c], exp_dp); end
         end else begin
            tests++; if (cap_dp[c] !== 1'b1) begin fails++; $display("FAIL zero_gap_dp c=%0d got %b want 1", c, cap_dp[c]); end
         end
      end
   endtask

   task automatic test_snapshot();
      logic [6:0] exp_seg;
      start_scan(16'h1111, 4'b0000, 1'b0);
      for (int c = 0; c < 40; c++) begin
         if (c == 11) digits_in = 16'h2222;
         step_sample(c);
      end
      for (int c = 0; c < 40; c++) begin
         if ((c % 5) < 4) begin
            exp_seg = (c < 20) ? G1 : G2;
            tests++; if (cap_seg[c] !== exp_seg) begin fails++; $display("FAIL snap_seg c=%0d got %b want %b", c, cap_seg[c], exp_seg); end
         end
      end
   endtask

   task automatic test_en_drop();
      int bad;
      start_scan(16'h1234, 4'b0000, 1'b0);
      for (int c = 0; c < 6; c++) step_sample(c);
      tests++; if (cap_an[5] !== 4'b1101) begin fails++; $display("FAIL drop_pre_an got %b want 1101", cap_an[5]); end
      en = 1'b0;
      @(negedge clk);
      tests++; if (an_out !== 4'b1101) begin fails++; $display("FAIL drop_lag_an got %b want 1101", an_out); end
      @(negedge clk);
      tests++; if (an_out !== 4'b1111) begin fails++; $display("FAIL drop_an got %b want 1111", an_out); end
      tests++; if (seg_out !== G_BLANK) begin fails++; $display("FAIL drop_seg got %b want %b", seg_out, G_BLANK); end
      bad = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (frame_done !== 1'b0 || an_out !== 4'b1111) bad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL drop_dark got %0d bad cycles want 0", bad); end
      en = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 20; c++) step_sample(c);
      tests++; if (cap_an[0] !== 4'b1110) begin fails++; $display("FAIL reen_an got %b want 1110", cap_an[0]); end
      tests++; if (cap_seg[0] !== G4) begin fails++; $display("FAIL reen_seg got %b want %b", cap_seg[0], G4); end
      bad = 0;
      for (int c = 0; c < 19; c++) if (cap_fd[c] !== 1'b0) bad++;
      tests++; if (bad !== 0) begin fails++; $display("FAIL reen_early_fd got %0d pulses want 0", bad); end
      tests++; if (cap_fd[19] !== 1'b1) begin fails++; $display("FAIL reen_fd got %b want 1", cap_fd[19]); end
   endtask

   task automatic test_async_reset();
      start_scan(16'h1234, 4'b0001, 1'b0);
      for (int c = 0; c < 4; c++) step_sample(c);
      tests++; if (cap_dp[3] !== 1'b0) begin fails++; $display("FAIL ar_pre_dp got %b want 0", cap_dp[3]); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (an_out !== 4'b1111) begin fails++; $display("FAIL ar_an got %b want 1111", an_out); end
      tests++; if (seg_out !== 7'b1111111) begin fails++; $display("FAIL ar_seg got %b want 1111111", seg_out); end
      tests++; if (dp_out !== 1'b1) begin fails++; $display("FAIL ar_dp got %b want 1", dp_out); end
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL ar_fd got %b want 0", frame_done); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 6; c++) step_sample(c);
      tests++; if (cap_an[0] !== 4'b1110) begin fails++; $display("FAIL ar_resume_an got %b want 1110", cap_an[0]); end
      tests++; if (cap_seg[0] !== G4) begin fails++; $display("FAIL ar_resume_seg got %b want %b", cap_seg[0], G4); end
      tests++; if (cap_an[5] !== 4'b1101) begin fails++; $display("FAIL ar_resume_d1 got %b want 1101", cap_an[5]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lz_hex();
      test_zero_dp();
      test_snapshot();
      test_en_drop();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
